// File: rtl/hid_act_serializer_pkg.sv
// hid_act_serializer_pkg: shared constants, FSM state and element type for the hidden-layer activation serializer
package hid_pkg;
  localparam int BIT_LENGTH = 16;
  localparam int HID_LENGTH = 24;
  localparam int DATA_N = 6;
  localparam int NBEATS = HID_LENGTH / DATA_N;
  localparam int CNT_W = $clog2(NBEATS);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_LOW} state_t;
  typedef logic signed [BIT_LENGTH-1:0] elem_t;
endpackage

// File: rtl/hid_act_serializer_act_unit.sv
// hid_act_unit: single-element activation, plain ReLU or leaky (x >>> 3) when HID_ACT_LEAKY_RELU_EN is defined
module hid_act_unit
  import hid_pkg::*;
(
  input  elem_t x,
  output elem_t y
);
`ifdef HID_ACT_LEAKY_RELU_EN
  assign y = x[BIT_LENGTH-1] ? x >>> 3 : x;
`else
  assign y = x[BIT_LENGTH-1] ? '0 : x;
`endif
endmodule

// File: rtl/hid_act_serializer.sv
// hid_act_serializer: captures the activated hidden vector on in_valid rise and streams it as DATA_N-lane beats (leaky path: HID_ACT_LEAKY_RELU_EN)
module hid_act_serializer
  import hid_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [HID_LENGTH*BIT_LENGTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_N*BIT_LENGTH-1:0]   out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           frame_done
);
  state_t state;
  logic in_valid_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] sel_cnt;
  logic [HID_LENGTH*BIT_LENGTH-1:0] buffer;
  logic [HID_LENGTH*BIT_LENGTH-1:0] act_data;
  logic [DATA_N*BIT_LENGTH-1:0] sel_data;
  logic start;
  assign start = in_valid & ~in_valid_q;
  for (genvar i = 0; i < HID_LENGTH; i++) begin : g_act
    hid_act_unit u_act (
      .x(in_data[i*BIT_LENGTH +: BIT_LENGTH]),
      .y(act_data[i*BIT_LENGTH +: BIT_LENGTH])
    );
  end
  // beat to load into the output register next: beat 0 from LOAD, otherwise the one after the current beat
  always_comb begin
    sel_cnt = (state == LOAD) ? '0 : beat_cnt + 1'b1;
    sel_data = buffer[int'(sel_cnt)*DATA_N*BIT_LENGTH +: DATA_N*BIT_LENGTH];
  end
  // capture/serialize FSM with registered outputs so out_ready never reaches out_valid combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_valid_q <= 1'b0;
      beat_cnt <= '0;
      buffer <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          buffer <= act_data;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          beat_cnt <= '0;
          out_valid <= 1'b1;
          out_data <= sel_data;
          out_last <= (NBEATS == 1);
          state <= SEND;
        end
        SEND: if (out_ready) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (out_last) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            busy <= 1'b0;
            frame_done <= 1'b1;
            state <= WAIT_LOW;
          end else begin
            out_data <= sel_data;
            out_last <= (beat_cnt == CNT_W'(NBEATS - 2));
          end
        end
        WAIT_LOW: if (!in_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hid_act_serializer.sv
// tb_hid_act_serializer: directed vectors with a scoreboard queue checked by a decoupled beat monitor
module tb_hid_act_serializer;
  localparam int BL = 16;
  localparam int HL = 24;
  localparam int DN = 6;
  localparam int NB = HL / DN;
  localparam int IW = HL * BL;
  localparam int OW = DN * BL;

  typedef struct {
    logic [OW-1:0] d;
    logic l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic out_last;
  logic busy;
  logic frame_done;

  int n_vec = 0;
  int n_err = 0;
  beat_t sb[$];
  logic prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic prev_last;

  hid_act_serializer dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops expected beats on every handshake and checks stability under backpressure
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && out_valid) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_last", OW'(out_last), OW'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_beat", OW'(1), OW'(0));
        else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_last", OW'(out_last), OW'(e.l));
        end
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_data = out_data;
    prev_last = out_last;
  end

  function automatic logic [IW-1:0] mk_seq();
    logic [IW-1:0] v;
    for (int i = 0; i < HL; i++) v[i*BL +: BL] = 16'(i + 1);
    return v;
  endfunction

  function automatic logic [IW-1:0] mk_const(input logic [BL-1:0] c);
    logic [IW-1:0] v;
    for (int i = 0; i < HL; i++) v[i*BL +: BL] = c;
    return v;
  endfunction

  function automatic logic [IW-1:0] mk_pat(input logic exp);
    logic [IW-1:0] v;
    logic [BL-1:0] p_in[4];
    logic [BL-1:0] p_ex[4];
    p_in = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
`ifdef HID_ACT_LEAKY_RELU_EN
    p_ex = '{16'hF000, 16'h7FFF, 16'hFFFF, 16'h0001};
`else
    p_ex = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0001};
`endif
    for (int i = 0; i < HL; i++) v[i*BL +: BL] = exp ? p_ex[i%4] : p_in[i%4];
    return v;
  endfunction

  task automatic push_beats(input logic [IW-1:0] exp, input int nbeats);
    for (int b = 0; b < nbeats; b++) sb.push_back('{d: exp[b*OW +: OW], l: (b == NB - 1)});
  endtask

  // called just after a posedge; that cycle is the start cycle t, frame_done is expected at negedge t+exp_cycles
  task automatic run_frame(input logic [IW-1:0] data, input logic [IW-1:0] exp, input int stall_len, input int drop_at, input int exp_cycles);
    int n;
    logic done;
    push_beats(exp, NB);
    in_data = data;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (n == 1) chk("valid_t1", OW'(out_valid), OW'(0));
      if (n == 2) begin
        chk("valid_t2", OW'(out_valid), OW'(1));
        chk("busy_t2", OW'(busy), OW'(1));
      end
      if (frame_done) begin
        done = 1'b1;
        chk("frame_done_cycle", OW'(n), OW'(exp_cycles));
      end else begin
        @(posedge clk);
        #1;
        n++;
        out_ready = !(n >= 3 && n < 3 + stall_len);
        if (drop_at > 0 && n == drop_at) in_valid = 1'b0;
      end
    end
    if (!done) chk("frame_done_timeout", OW'(n), OW'(exp_cycles));
    @(negedge clk);
    chk("frame_done_pulse", OW'(frame_done), OW'(0));
    chk("busy_after", OW'(busy), OW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic drop_one();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", OW'(out_valid), OW'(0));
    chk("rst_data", out_data, OW'(0));
    chk("rst_last", OW'(out_last), OW'(0));
    chk("rst_busy", OW'(busy), OW'(0));
    chk("rst_frame_done", OW'(frame_done), OW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(mk_seq(), mk_seq(), 0, 0, 6);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_no_frame", OW'({out_valid, busy}), OW'(0));
    end
    @(posedge clk);
    #1;
    drop_one();
    run_frame(mk_const(16'd100), mk_const(16'd100), 0, 0, 6);
    drop_one();
    run_frame(mk_pat(1'b0), mk_pat(1'b1), 0, 0, 6);
    drop_one();
    run_frame(mk_seq(), mk_seq(), 3, 0, 9);
    drop_one();
    run_frame(mk_pat(1'b0), mk_pat(1'b1), 0, 3, 6);
    drop_one();
    push_beats(mk_seq(), 2);
    in_data = mk_seq();
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", OW'(out_valid), OW'(0));
    chk("abort_data", out_data, OW'(0));
    chk("abort_busy", OW'(busy), OW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(mk_seq(), mk_seq(), 0, 0, 6);
    drop_one();
    repeat (3) @(posedge clk);
    chk("sb_empty", OW'(sb.size()), OW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
